booth_r4_multiplier: RTL and testbench

//  Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.

---
 rtl/booth_r4_multiplier_pkg.sv | 30 +++
 rtl/booth_r4_multiplier_if.sv | 25 ++
 rtl/booth_r4_multiplier_recoder.sv | 28 ++
 rtl/booth_r4_multiplier.sv | 115 +++++++++++
 tb/tb_booth_r4_multiplier.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/booth_r4_multiplier_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states and recoded Booth digits.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } booth_digit_e;

    function automatic booth_digit_e booth_decode(input logic [2:0] bits);
        booth_digit_e d;
        case (bits)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_multiplier_if.sv
// Operand/result handshake bundle for booth_r4_multiplier.
interface booth_r4_multiplier_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               signed_mode;
    logic               abort;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport master (
        output in_valid, multiplicand, multiplier, signed_mode, abort, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, signed_mode, abort, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_r4_multiplier_recoder.sv
// Combinational radix-4 Booth recoder: three multiplier bits select 0, +/-M or +/-2M.
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int E = 10
) (
    input  logic [2:0]   bits,
    input  logic [E-1:0] m_ext,
    output logic [E:0]   addend
);
    booth_digit_e digit;
    logic [E:0]   m1;
    logic [E:0]   m2;

    always_comb begin
        m1     = {m_ext[E-1], m_ext};
        m2     = {m_ext, 1'b0};
        digit  = booth_decode(bits);
        addend = '0;
        case (digit)
            P1:      addend = m1;
            P2:      addend = m2;
            M1:      addend = -m1;
            M2:      addend = -m2;
            default: addend = '0;
        endcase
    end
endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per op,
// with valid/ready on both sides and synchronous abort.
module booth_r4_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    booth_r4_multiplier_if.slave bus
);
    localparam int E  = WIDTH + 2;
    localparam int N  = E / 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_bad_width
        $error("booth_r4_multiplier: WIDTH must be even and >= 4");
    end

    state_e             state;
    state_e             state_next;
    logic [E:0]         acc;
    logic [E-1:0]       q_reg;
    logic               q_1;
    logic [E-1:0]       m_ext;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product_r;

    logic [E:0]         addend;
    logic [E:0]         sum;
    logic [2*E+1:0]     shifted;
    logic               accept;
    logic               last_step;

    booth_r4_recoder #(.E(E)) u_recoder (
        .bits   ({q_reg[1:0], q_1}),
        .m_ext  (m_ext),
        .addend (addend)
    );

    // Abort outranks the input handshake, so a cancelled cycle never accepts.
    assign accept    = (state == IDLE) && bus.in_valid && !bus.abort;
    assign last_step = (count == LAST);

    always_comb begin
        sum     = acc + addend;
        shifted = $unsigned($signed({sum, q_reg, q_1}) >>> 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = CALC;
            CALC: begin
                if (bus.abort)     state_next = IDLE;
                else if (last_step) state_next = DONE;
            end
            DONE: if (bus.abort || bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            q_reg     <= '0;
            q_1       <= 1'b0;
            m_ext     <= '0;
            count     <= '0;
            product_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_ext <= bus.signed_mode ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                                 : {2'b00, bus.multiplicand};
                        q_reg <= bus.signed_mode ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                                 : {2'b00, bus.multiplier};
                        acc   <= '0;
                        q_1   <= 1'b0;
                        count <= '0;
                    end
                end
                CALC: begin
                    if (bus.abort) begin
                        count <= '0;
                    end else begin
                        acc   <= shifted[2*E+1:E+1];
                        q_reg <= shifted[E:1];
                        q_1   <= shifted[0];
                        count <= count + CW'(1);
                        // {A,Q} low half sits one bit above Q_1 in the shifted word.
                        if (last_step) product_r <= shifted[2*WIDTH:1];
                    end
                end
                DONE: begin
                    if (bus.abort) count <= '0;
                end
                default: count <= '0;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.product   = product_r;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Directed and randomized self-checking bench for booth_r4_multiplier at WIDTH=8.
module tb_booth_r4_multiplier;
    import booth_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    booth_r4_multiplier_if #(.WIDTH(8)) bus ();

    booth_r4_multiplier #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] m, input logic [7:0] q, input logic s);
        int unsigned n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.signed_mode  = s;
        bus.in_valid     = 1'b1;
        @(posedge clk); #1;
        bus.in_valid     = 1'b0;
        bus.multiplicand = 8'hA5;
        bus.multiplier   = 8'h5A;
        bus.signed_mode  = ~s;
    endtask

    task automatic wait_result(output logic [15:0] p, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) check_eq("out_valid_timeout", 32'(bus.out_valid), 32'd1);
        p = bus.product;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                          input logic s, input logic [15:0] exp);
        logic [15:0] p;
        int lat;
        start_op(m, q, s);
        wait_result(p, lat);
        check_eq(tag, 32'(p), 32'(exp));
        take_result();
    endtask

    initial begin
        logic [15:0] p;
        logic [15:0] held;
        logic [15:0] exp;
        int lat;
        int a;
        int b;
        logic [7:0] rm;
        logic [7:0] rq;
        logic rs;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid     = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.signed_mode  = 1'b0;
        bus.abort        = 1'b0;
        bus.out_ready    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_busy",      32'(bus.busy),      32'd0);
        check_eq("rst_product",   32'(bus.product),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // -3 * 7 with latency check
        start_op(8'hFD, 8'h07, 1'b1);
        check_eq("calc_busy", 32'(bus.busy), 32'd1);
        check_eq("calc_in_ready", 32'(bus.in_ready), 32'd0);
        wait_result(p, lat);
        check_eq("latency", 32'(lat), 32'd5);
        check_eq("signed_m3x7", 32'(p), 32'h0000FFEB);
        take_result();

        run_op("unsigned_ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op("signed_m1xm1",   8'hFF, 8'hFF, 1'b1, 16'h0001);
        run_op("signed_80x80",   8'h80, 8'h80, 1'b1, 16'h4000);
        run_op("unsigned_80x80", 8'h80, 8'h80, 1'b0, 16'h4000);
        run_op("zero_x_5a",      8'h00, 8'h5A, 1'b1, 16'h0000);
        run_op("signed_7fx80",   8'h7F, 8'h80, 1'b1, 16'hC080);

        // Back-pressure: result held while out_ready stays low
        start_op(8'h0B, 8'h0D, 1'b0);
        wait_result(held, lat);
        check_eq("bp_product", 32'(held), 32'h0000008F);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check_eq("bp_stable",    32'(bus.product),   32'(held));
            check_eq("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        take_result();
        check_eq("bp_released_valid", 32'(bus.out_valid), 32'd0);
        check_eq("bp_released_ready", 32'(bus.in_ready),  32'd1);

        // Abort in the third CALC cycle
        start_op(8'h55, 8'h33, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check_eq("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_product",   32'(bus.product),   32'(held));
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                if (bus.out_valid || bus.busy) seen++;
            end
            check_eq("abort_quiet", 32'(seen), 32'd0);
        end
        run_op("after_abort_12x34", 8'h12, 8'h34, 1'b0, 16'h03A8);

        // Abort in DONE beats out_ready
        start_op(8'h02, 8'h03, 1'b0);
        wait_result(p, lat);
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("done_abort_valid",   32'(bus.out_valid), 32'd0);
        check_eq("done_abort_product", 32'(bus.product),   32'h00000006);

        // Abort in IDLE blocks a simultaneous accept
        bus.multiplicand = 8'h04;
        bus.multiplier   = 8'h04;
        bus.in_valid     = 1'b1;
        bus.abort        = 1'b1;
        @(posedge clk); #1;
        bus.in_valid     = 1'b0;
        bus.abort        = 1'b0;
        check_eq("idle_abort_no_accept", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid-CALC
        start_op(8'h21, 8'h43, 1'b1);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("arst_product",   32'(bus.product),   32'd0);
        check_eq("arst_busy",      32'(bus.busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random sweep against integer reference with random back-pressure
        for (int i = 0; i < 1000; i++) begin
            rm = 8'($urandom);
            rq = 8'($urandom);
            rs = 1'($urandom);
            a  = rs ? int'($signed(rm)) : int'(rm);
            b  = rs ? int'($signed(rq)) : int'(rq);
            exp = 16'(a * b);
            start_op(rm, rq, rs);
            wait_result(p, lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            check_eq("rand", 32'(bus.product), 32'(exp));
            take_result();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
